// File: rtl/spi_slave_if_pkg.sv
// Shared types and constants for the SPI mode-0 slave front end.
package spi_slave_if_pkg;

    localparam int BYTE_W_DEF = 8;

    typedef enum logic [1:0] {
        S_WAIT_HI = 2'd0,
        S_IDLE    = 2'd1,
        S_ACTIVE  = 2'd2
    } spi_state_t;

    function automatic int cnt_width(input int byte_w);
        return (byte_w > 1) ? $clog2(byte_w) : 1;
    endfunction

    localparam int BIT_CNT_W = cnt_width(BYTE_W_DEF);

endpackage

// File: rtl/spi_slave_if_if.sv
// SPI pin and controller-side bundle for spi_slave_if; frame_err exists only with SPI_FRAME_ERR_EN.
// Handshake: rx_stb and tsx_start are single-cycle pulses with no back-pressure; rx_data is valid
// from the rx_stb cycle until the next rx_stb, and tx_data is sampled continuously between bytes.
interface spi_slave_if_if import spi_slave_if_pkg::*; #(
    parameter int BYTE_W = BYTE_W_DEF
);
    localparam int CNT_W = cnt_width(BYTE_W);

    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_cs_n;
    logic              spi_miso;
    logic [BYTE_W-1:0] tx_data;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_stb;
    logic              tsx_start;
    spi_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
`ifdef SPI_FRAME_ERR_EN
    logic              frame_err;

    modport slave (
        input  spi_sck, spi_mosi, spi_cs_n, tx_data,
        output spi_miso, rx_data, rx_stb, tsx_start, state, bit_cnt, frame_err
    );
    modport master (
        output spi_sck, spi_mosi, spi_cs_n, tx_data,
        input  spi_miso, rx_data, rx_stb, tsx_start, state, bit_cnt, frame_err
    );
`else
    modport slave (
        input  spi_sck, spi_mosi, spi_cs_n, tx_data,
        output spi_miso, rx_data, rx_stb, tsx_start, state, bit_cnt
    );
    modport master (
        output spi_sck, spi_mosi, spi_cs_n, tx_data,
        input  spi_miso, rx_data, rx_stb, tsx_start, state, bit_cnt
    );
`endif

endinterface

// File: rtl/spi_slave_if_sync_ff.sv
// Multi-stage synchroniser for one asynchronous input, with a selectable reset value.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: synchronises pins, deserialises MOSI, serialises tx_data on MISO.
// Optional SPI_FRAME_ERR_EN adds a frame_err pulse when CS_N rises on a partial byte.
module spi_slave_if import spi_slave_if_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int BYTE_W      = BYTE_W_DEF
) (
    input logic           clk,
    input logic           rst,
    spi_slave_if_if.slave bus
);
    localparam int                CNT_W    = cnt_width(BYTE_W);
    localparam int                SETTLE_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BYTE_W - 1);
    localparam logic [SETTLE_W-1:0] SETTLED = SETTLE_W'(SYNC_STAGES);

    logic sck_s, mosi_s, cs_s;
    logic sck_d, cs_d;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    spi_state_t          state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [BYTE_W-2:0]   rx_sh;
    logic [BYTE_W-1:0]   rx_next;
    logic [BYTE_W-1:0]   tx_sh;
    logic [BYTE_W-1:0]   rx_data_r;
    logic                byte_done;
    logic                rx_stb_r;
    logic                tsx_start_r;
    logic                frame_err_r;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst(rst), .d(bus.spi_sck),  .q(sck_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(bus.spi_mosi), .q(mosi_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d(bus.spi_cs_n), .q(cs_s));

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign rx_next  = {rx_sh, mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_d       <= 1'b0;
            cs_d        <= 1'b1;
            state       <= S_WAIT_HI;
            bit_cnt     <= '0;
            settle_cnt  <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            rx_data_r   <= '0;
            byte_done   <= 1'b0;
            rx_stb_r    <= 1'b0;
            tsx_start_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            sck_d       <= sck_s;
            cs_d        <= cs_s;
            byte_done   <= 1'b0;
            rx_stb_r    <= byte_done;
            tsx_start_r <= 1'b0;
            frame_err_r <= 1'b0;

            // Between bytes MISO follows tx_data; the first SCK rise of a byte freezes it.
            if (bit_cnt == '0 && !sck_rise) begin
                tx_sh <= bus.tx_data;
            end else if (state == S_ACTIVE && sck_fall) begin
                tx_sh <= {tx_sh[BYTE_W-2:0], 1'b0};
            end

            case (state)
                // The CS synchroniser resets high, so wait for it to flush before trusting it.
                S_WAIT_HI: begin
                    bit_cnt <= '0;
                    if (settle_cnt != SETTLED) begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end else if (cs_s) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (cs_fall) begin
                        tsx_start_r <= 1'b1;
                        bit_cnt     <= '0;
                        state       <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (cs_rise) begin
                        frame_err_r <= (bit_cnt != '0);
                        bit_cnt     <= '0;
                        state       <= S_IDLE;
                    end else if (sck_rise) begin
                        rx_sh <= rx_next[BYTE_W-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt   <= '0;
                            rx_data_r <= rx_next;
                            byte_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_WAIT_HI;
            endcase
        end
    end

    assign bus.spi_miso  = tx_sh[BYTE_W-1];
    assign bus.rx_data   = rx_data_r;
    assign bus.rx_stb    = rx_stb_r;
    assign bus.tsx_start = tsx_start_r;
    assign bus.state     = state;
    assign bus.bit_cnt   = bit_cnt;
`ifdef SPI_FRAME_ERR_EN
    assign bus.frame_err = frame_err_r;
`else
    logic unused_frame_err;
    assign unused_frame_err = frame_err_r;
`endif

endmodule
